// File: rtl/ir_fetch_pkg.sv
// ============================================================================
// Module   : ir_fetch_pkg
// Brief    : Shared types and encodings for the instruction fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ir_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RD_LO = 3'd2,
        S_LD_LO = 3'd3,
        S_RD_HI = 3'd4,
        S_LD_HI = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    localparam logic [1:0] FUNSEL_CLR  = 2'b00;
    localparam logic [1:0] FUNSEL_LOAD = 2'b01;
    localparam logic [1:0] FUNSEL_DEC  = 2'b10;
    localparam logic [1:0] FUNSEL_INC  = 2'b11;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ir_fetch_ctrl_pc_reg.sv
// ============================================================================
// Module   : fetch_pc_reg
// Brief    : Program counter with synchronous reset, load and increment
//            (load wins over increment; increment wraps modulo 2^ADDR_W).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_reg #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/ir_fetch_ctrl.sv
// ============================================================================
// Module   : ir_fetch_ctrl
// Brief    : Fetches two little-endian bytes and writes them into the 16-bit
//            instruction register. Optional clear cycle: IR_FETCH_CLR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_fetch_ctrl
    import ir_fetch_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              ir_e,
    output logic [1:0]        ir_funsel,
    output logic              ir_l_h,
    output logic [DATA_W-1:0] ir_i_half,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_done
);

`ifdef IR_FETCH_CLR_EN
    localparam state_e START_ST = S_CLR;
`else
    localparam state_e START_ST = S_RD_LO;
`endif

    state_e            state_q, state_d;
    logic              pc_load_en;
    logic              pc_inc;
    logic              accept;

    logic              mem_rd_q,     mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              ir_e_q,       ir_e_d;
    logic [1:0]        ir_funsel_q,  ir_funsel_d;
    logic              ir_l_h_q,     ir_l_h_d;
    logic [DATA_W-1:0] ir_i_half_q,  ir_i_half_d;
    logic              busy_q,       busy_d;
    logic              fetch_done_q, fetch_done_d;

    fetch_pc_reg #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load_en),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    // Only a valid seen while a request is actually outstanding completes it.
    assign accept = mem_rd_q && mem_valid;

    always_comb begin
        state_d    = state_q;
        pc_load_en = 1'b0;
        pc_inc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pc_load) begin
                    pc_load_en = 1'b1;
                end else if (run) begin
                    state_d = START_ST;
                end
            end
            S_CLR:   state_d = S_RD_LO;
            S_RD_LO: begin
                if (accept) begin
                    pc_inc  = 1'b1;
                    state_d = S_LD_LO;
                end
            end
            S_LD_LO: state_d = S_RD_HI;
            S_RD_HI: begin
                if (accept) begin
                    pc_inc  = 1'b1;
                    state_d = S_LD_HI;
                end
            end
            S_LD_HI: state_d = S_DONE;
            S_DONE:  state_d = run ? START_ST : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers line up with state_q.
    // pc never moves on a transition into a read state, so pc is the address.
    always_comb begin
        mem_rd_d     = (state_d == S_RD_LO) || (state_d == S_RD_HI);
        mem_addr_d   = mem_rd_d ? pc : mem_addr_q;
        ir_e_d       = (state_d == S_CLR) || (state_d == S_LD_LO) || (state_d == S_LD_HI);
        ir_funsel_d  = ((state_d == S_LD_LO) || (state_d == S_LD_HI)) ? FUNSEL_LOAD : FUNSEL_CLR;
        ir_l_h_d     = (state_d == S_LD_HI) ? HALF_HI : HALF_LO;
        ir_i_half_d  = accept ? mem_data : ir_i_half_q;
        busy_d       = (state_d != S_IDLE);
        fetch_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            ir_e_q       <= 1'b0;
            ir_funsel_q  <= FUNSEL_CLR;
            ir_l_h_q     <= HALF_LO;
            ir_i_half_q  <= '0;
            busy_q       <= 1'b0;
            fetch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            ir_e_q       <= ir_e_d;
            ir_funsel_q  <= ir_funsel_d;
            ir_l_h_q     <= ir_l_h_d;
            ir_i_half_q  <= ir_i_half_d;
            busy_q       <= busy_d;
            fetch_done_q <= fetch_done_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign ir_e       = ir_e_q;
    assign ir_funsel  = ir_funsel_q;
    assign ir_l_h     = ir_l_h_q;
    assign ir_i_half  = ir_i_half_q;
    assign busy       = busy_q;
    assign fetch_done = fetch_done_q;

endmodule

`default_nettype wire

// File: tb/tb_ir_fetch_ctrl.sv
// ============================================================================
// Module   : tb_ir_fetch_ctrl
// Brief    : Directed self-checking bench for ir_fetch_ctrl with a wait-state
//            memory responder and an instruction register model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ir_fetch_ctrl;

`ifdef IR_FETCH_CLR_EN
    localparam int FETCH_CYC = 6;
    localparam bit EXP_CLR   = 1'b1;
`else
    localparam int FETCH_CYC = 5;
    localparam bit EXP_CLR   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       pc_load = 1'b0;
    logic [7:0] pc_load_val = 8'h00;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic       mem_valid = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic       ir_e;
    logic [1:0] ir_funsel;
    logic       ir_l_h;
    logic [7:0] ir_i_half;
    logic [7:0] pc;
    logic       busy;
    logic       fetch_done;

    ir_fetch_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .ir_e        (ir_e),
        .ir_funsel   (ir_funsel),
        .ir_l_h      (ir_l_h),
        .ir_i_half   (ir_i_half),
        .pc          (pc),
        .busy        (busy),
        .fetch_done  (fetch_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: answers after 'waits' extra cycles of mem_rd.
    logic [7:0] mem [256];
    int         waits = 0;
    int         wcnt = 0;
    logic [7:0] req_addr = 8'h00;
    int         addr_moved = 0;
    int         rd_len_q[$];

    always @(negedge clk) begin
        if (!mem_rd || rst) begin
            mem_valid = 1'b0;
            wcnt = 0;
        end else begin
            if (wcnt == 0) req_addr = mem_addr;
            else if (mem_addr !== req_addr) addr_moved++;
            if (wcnt >= waits) begin
                mem_valid = 1'b1;
                mem_data  = mem[mem_addr];
                rd_len_q.push_back(wcnt + 1);
            end else begin
                mem_valid = 1'b0;
            end
            wcnt++;
        end
    end

    // Instruction register model driven by the controller's load port.
    logic [15:0] ir_model = 16'h0000;
    int          clr_cnt = 0;
    int          bad_funsel = 0;

    always @(posedge clk) begin
        if (ir_e) begin
            case (ir_funsel)
                2'b00: ir_model <= 16'h0000;
                2'b01: if (ir_l_h) ir_model[15:8] <= ir_i_half;
                       else        ir_model[7:0]  <= ir_i_half;
                2'b10: ir_model <= ir_model - 16'd1;
                default: ir_model <= ir_model + 16'd1;
            endcase
            if (ir_funsel == 2'b00) clr_cnt++;
            if (ir_funsel[1]) bad_funsel++;
        end
    end

    task automatic rst_pulse();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns cycles counted up to the fetch_done cycle.
    task automatic wait_done(input bit hold_run, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!hold_run) run = 1'b0;
        end while (!fetch_done && cyc < 200);
    endtask

    task automatic fetch_one(output int cyc);
        run = 1'b1;
        wait_done(1'b0, cyc);
    endtask

    int cyc;
    int lim;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_pc",        32'(pc),         32'h00);
        check("rst_mem_rd",    32'(mem_rd),     32'h0);
        check("rst_mem_addr",  32'(mem_addr),   32'h00);
        check("rst_ir_e",      32'(ir_e),       32'h0);
        check("rst_funsel",    32'(ir_funsel),  32'h0);
        check("rst_l_h",       32'(ir_l_h),     32'h0);
        check("rst_i_half",    32'(ir_i_half),  32'h00);
        check("rst_busy",      32'(busy),       32'h0);
        check("rst_done",      32'(fetch_done), 32'h0);

        // Single zero-wait fetch.
        mem[8'h00] = 8'hAA; mem[8'h01] = 8'h33;
        fetch_one(cyc);
        check("t1_cycles", 32'(cyc),      32'(FETCH_CYC));
        check("t1_ir",     32'(ir_model), 32'h33AA);
        check("t1_pc",     32'(pc),       32'h02);
        @(negedge clk);
        check("t1_idle",   32'(busy),     32'h0);

        // Back-to-back with run held high.
        rst_pulse();
        mem[0] = 8'h4C; mem[1] = 8'h4C; mem[2] = 8'h55;
        mem[3] = 8'h66; mem[4] = 8'hF0; mem[5] = 8'h01;
        run = 1'b1;
        wait_done(1'b1, cyc);
        check("t2_ir0", 32'(ir_model), 32'h4C4C);
        wait_done(1'b1, cyc);
        check("t2_gap1", 32'(cyc), 32'(FETCH_CYC));
        check("t2_ir1", 32'(ir_model), 32'h6655);
        wait_done(1'b1, cyc);
        run = 1'b0;
        check("t2_gap2", 32'(cyc), 32'(FETCH_CYC));
        check("t2_ir2", 32'(ir_model), 32'h01F0);
        @(negedge clk);
        check("t2_pc", 32'(pc), 32'h06);

        // Three wait states per byte.
        rst_pulse();
        mem[0] = 8'h9E; mem[1] = 8'h07;
        waits = 3;
        addr_moved = 0;
        rd_len_q.delete();
        fetch_one(cyc);
        check("t3_cycles",   32'(cyc), 32'(FETCH_CYC + 6));
        check("t3_ir",       32'(ir_model), 32'h079E);
        check("t3_nreq",     32'(rd_len_q.size()), 32'd2);
        check("t3_len_lo",   32'((rd_len_q.size() > 0) ? rd_len_q[0] : 0), 32'd4);
        check("t3_len_hi",   32'((rd_len_q.size() > 1) ? rd_len_q[1] : 0), 32'd4);
        check("t3_addr_stb", 32'(addr_moved), 32'd0);
        waits = 0;
        @(negedge clk);

        // pc_load in the same IDLE cycle as run, then a wrap-straddling fetch.
        pc_load = 1'b1; pc_load_val = 8'hFF; run = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        check("t4_pc_load", 32'(pc),   32'hFF);
        check("t4_no_start", 32'(busy), 32'h0);
        mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
        fetch_one(cyc);
        check("t4_ir", 32'(ir_model), 32'h3412);
        check("t4_pc", 32'(pc),       32'h01);
        @(negedge clk);

        // Reset in the middle of the high-byte read.
        rst_pulse();
        mem[0] = 8'h5A; mem[1] = 8'hC3;
        waits = 3;
        run = 1'b1;
        lim = 0;
        do begin
            @(negedge clk);
            run = 1'b0;
            lim++;
        end while (!(mem_rd && mem_addr == 8'h01) && lim < 50);
        check("t5_reach_rd_hi", 32'(mem_rd && mem_addr == 8'h01), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy",   32'(busy),   32'h0);
        check("t5_pc",     32'(pc),     32'h00);
        check("t5_mem_rd", 32'(mem_rd), 32'h0);
        check("t5_ir_e",   32'(ir_e),   32'h0);
        waits = 0;
        @(negedge clk);
        fetch_one(cyc);
        check("t5_cycles", 32'(cyc),      32'(FETCH_CYC));
        check("t5_ir",     32'(ir_model), 32'hC35A);
        check("t5_pc",     32'(pc),       32'h02);
        @(negedge clk);

        check("clr_emitted", 32'(clr_cnt != 0), 32'(EXP_CLR));
        check("funsel_1x",   32'(bad_funsel),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
